// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble converter.
// Used by bin2bcd_seq and its bcd_digit_adj cells.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [3:0] BCD_ADJ    = 4'd3;
  localparam logic [3:0] BCD_THRESH = 4'd5;

  // Decimal digits needed to show 2**width-1, i.e. ceil(width*log10(2)).
  function automatic int digits_for(input int width);
    longint unsigned maxval;
    longint unsigned pow;
    int d;
    maxval = (64'd1 << width) - 64'd1;
    pow    = 64'd10;
    d      = 1;
    while (pow <= maxval) begin
      d   = d + 1;
      pow = pow * 64'd10;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the shift-and-add-3 step: digits of 5 or more get +3
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= BCD_THRESH) ? d + BCD_ADJ : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one operand bit per clock.
// Define BIN2BCD_BLANK_EN to drive the leading-zero blanking flags.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 9,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  // With enough digits nothing can ever leave the top of the scratch.
  localparam bit OVF_POSSIBLE = (DIGITS < digits_for(BIN_W));

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [SW-1:0]          scratch;
  logic [SW-1:0]          adjusted;
  logic [BIN_W-1:0]       operand;
  logic                   sticky;
  logic [SW+BIN_W-1:0]    shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d(scratch[4*g +: 4]),
      .q(adjusted[4*g +: 4])
    );
  end

  // Bit leaving the top of the scratch is adjusted[SW-1]; it feeds sticky.
  assign shifted = {adjusted[SW-2:0], operand, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      scratch  <= '0;
      operand  <= '0;
      sticky   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            scratch <= '0;
            operand <= bin;
            cnt     <= CW'(BIN_W);
            sticky  <= 1'b0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, operand} <= shifted;
          sticky             <= sticky | adjusted[SW-1];
          cnt                <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          bcd      <= scratch;
          overflow <= OVF_POSSIBLE && sticky;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_next;
  logic              all_zero;

  // Digit i blanks when it and every digit above it are zero; digit 0 never does.
  always_comb begin
    blank_next = '0;
    all_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero      = all_zero && (scratch[4*i +: 4] == 4'd0);
      blank_next[i] = all_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blank <= ~DIGITS'(1);
    end else if (state == DONE) begin
      blank <= blank_next;
    end
  end
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: scoreboarded default instance plus
// directed checks on a 16-bit/5-digit and an undersized 9-bit/2-digit build.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b, start_c;
  logic [8:0]  bin_a, bin_c;
  logic [15:0] bin_b;

  logic        busy_a, done_a, overflow_a;
  logic [11:0] bcd_a;
  logic [2:0]  blank_a;
  logic        busy_b, done_b, overflow_b;
  logic [19:0] bcd_b;
  logic [4:0]  blank_b;
  logic        busy_c, done_c, overflow_c;
  logic [7:0]  bcd_c;
  logic [1:0]  blank_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_edge = -1000;
  int next_accept = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [11:0] bcd;
    int          due;
  } sb_t;
  sb_t sbq[$];

  bin2bcd_seq #(.BIN_W(9), .DIGITS(3)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(overflow_a), .blank(blank_a)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(overflow_b), .blank(blank_b)
  );

  bin2bcd_seq #(.BIN_W(9), .DIGITS(2)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .bin(bin_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(overflow_c), .blank(blank_c)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd3(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] blank3(input logic [11:0] b);
    logic [2:0] r;
    r = 3'b000;
`ifdef BIN2BCD_BLANK_EN
    r[2] = (b[11:8] == 4'd0);
    r[1] = (b[11:4] == 8'd0);
`endif
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [8:0] value, input int hold);
    bin_a   = value;
    start_a = 1'b1;
    repeat (hold) @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  // Timing model of the default instance: which edges accept, when done is due.
  always @(posedge clk) begin : model
    int e;
    e = cyc + 1;
    cyc <= e;
    if (rst) begin
      sbq.delete();
      acc_edge    <= -1000;
      next_accept <= e + 1;
    end else if (start_a && e >= next_accept) begin
      sbq.push_back('{to_bcd3(int'(bin_a)), e + 10});
      acc_edge    <= e;
      next_accept <= e + 11;
    end
  end

  // Every cycle: busy/done against the model, results against the scoreboard.
  always @(negedge clk) begin : monitor
    logic exp_busy, exp_done;
    sb_t  ent;
    if (mon_en) begin
      exp_busy = (acc_edge >= 0) && (cyc >= acc_edge) && (cyc <= acc_edge + 8);
      exp_done = (sbq.size() != 0) && (sbq[0].due == cyc);
      checkOutput("busy_a", 32'(busy_a), 32'(exp_busy));
      checkOutput("done_a", 32'(done_a), 32'(exp_done));
      if (exp_done) begin
        ent = sbq.pop_front();
        checkOutput("bcd_a", 32'(bcd_a), 32'(ent.bcd));
        checkOutput("overflow_a", 32'(overflow_a), 32'd0);
        checkOutput("blank_a", 32'(blank_a), 32'(blank3(ent.bcd)));
      end
    end
  end

  initial begin
    int lat;
    int vals[6] = '{7, 5, 10, 99, 255, 1};
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    bin_a = '0; bin_b = '0; bin_c = '0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    checkOutput("rst_bcd_a", 32'(bcd_a), 32'd0);
    checkOutput("rst_ovf_a", 32'(overflow_a), 32'd0);
    checkOutput("rst_blank_a", 32'(blank_a), 32'(blank3(12'h000)));
    checkOutput("rst_bcd_b", 32'(bcd_b), 32'd0);
    checkOutput("rst_busy_b", 32'(busy_b), 32'd0);
    checkOutput("rst_done_c", 32'(done_c), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] max value 511");
    applyStimulus(9'd511, 1);
    waitDrain();
    checkOutput("hold_511", 32'(bcd_a), 32'h511);

    $display("[TB] back to back, second start during DONE");
    applyStimulus(9'd0, 1);
    repeat (9) @(negedge clk);
    applyStimulus(9'd100, 2);
    waitDrain();
    checkOutput("hold_100", 32'(bcd_a), 32'h100);

    $display("[TB] start held high, operand changing");
    for (int i = 0; i < 40; i++) begin
      bin_a   = 9'($urandom_range(0, 511));
      start_a = 1'b1;
      @(negedge clk);
    end
    start_a = 1'b0;
    waitDrain();

    $display("[TB] reset mid-conversion");
    applyStimulus(9'd300, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_bcd", 32'(bcd_a), 32'd0);
    checkOutput("abort_ovf", 32'(overflow_a), 32'd0);
    checkOutput("abort_blank", 32'(blank_a), 32'(blank3(12'h000)));
    repeat (15) @(negedge clk);
    applyStimulus(9'd42, 1);
    waitDrain();
    checkOutput("hold_042", 32'(bcd_a), 32'h042);

    $display("[TB] directed values");
    foreach (vals[k]) begin
      applyStimulus(9'(vals[k]), 1);
      waitDrain();
    end

    $display("[TB] 16-bit, 5 digits");
    bin_b   = 16'hFFFF;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    bin_b   = 16'h0000;
    lat = 0;
    while (done_b !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("lat_b", 32'(lat), 32'd17);
    checkOutput("bcd_b", 32'(bcd_b), 32'h65535);
    checkOutput("ovf_b", 32'(overflow_b), 32'd0);
    checkOutput("blank_b", 32'(blank_b), 32'd0);

    $display("[TB] 9-bit, 2 digits, overflow");
    bin_c   = 9'd123;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    lat = 0;
    while (done_c !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("lat_c", 32'(lat), 32'd10);
    checkOutput("bcd_c", 32'(bcd_c), 32'h23);
    checkOutput("ovf_c", 32'(overflow_c), 32'd1);
    checkOutput("blank_c", 32'(blank_c), 32'd0);
    @(negedge clk);
    checkOutput("done_c_pulse", 32'(done_c), 32'd0);
    checkOutput("ovf_c_held", 32'(overflow_c), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
